// File: rtl/axis_pkg.sv
// Shared helpers for the AXI4-Stream ingress: tkeep width derivation, byte counting
// and tkeep shape classification.
package axis_pkg;

    localparam int KEEP_MAX = 64;

    typedef enum logic [1:0] {
        KEEP_OK    = 2'd0,
        KEEP_EMPTY = 2'd1,
        KEEP_GAP   = 2'd2,
        KEEP_SHORT = 2'd3
    } keep_chk_e;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic [7:0] keep_popcount(input logic [KEEP_MAX-1:0] keep);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            n = n + {7'd0, keep[i]};
        end
        return n;
    endfunction

    // A contiguous-from-bit-0 mask has no set bit above a clear one: keep & (keep+1) == 0.
    function automatic logic keep_is_contiguous(input logic [KEEP_MAX-1:0] keep);
        return (keep & (keep + KEEP_MAX'(1))) == '0;
    endfunction

    function automatic keep_chk_e keep_classify(input logic [KEEP_MAX-1:0] keep,
                                                input logic last, input logic full);
        keep_chk_e r;
        r = KEEP_OK;
        if (keep == '0) begin
            r = KEEP_EMPTY;
        end else if (!keep_is_contiguous(keep)) begin
            r = KEEP_GAP;
        end else if (!last && !full) begin
            r = KEEP_SHORT;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO holding data, keep, last and user per entry; pointer plus count,
// head outputs forced to zero while empty.
module axis_sync_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic [KEEP_WIDTH-1:0]     push_keep,
    input  logic                      push_last,
    input  logic                      push_user,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     head_data,
    output logic [KEEP_WIDTH-1:0]     head_keep,
    output logic                      head_last,
    output logic                      head_user,
    output logic                      head_valid,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
    logic [KEEP_WIDTH-1:0] keep_mem_q [DEPTH];
    logic [KEEP_WIDTH-1:0] keep_mem_d [DEPTH];
    logic [DEPTH-1:0]      last_mem_q, last_mem_d;
    logic [DEPTH-1:0]      user_mem_q, user_mem_d;
    logic                  wr_en, rd_en;

    assign full       = (count_q == FULL_CNT);
    assign head_valid = (count_q != '0);
    assign count      = count_q;
    assign wr_en      = push & ~full;
    assign rd_en      = pop & head_valid;

    assign head_data = head_valid ? data_mem_q[rd_ptr_q] : '0;
    assign head_keep = head_valid ? keep_mem_q[rd_ptr_q] : '0;
    assign head_last = head_valid & last_mem_q[rd_ptr_q];
    assign head_user = head_valid & user_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_mem_d = data_mem_q;
        keep_mem_d = keep_mem_q;
        last_mem_d = last_mem_q;
        user_mem_d = user_mem_q;
        if (wr_en) begin
            data_mem_d[wr_ptr_q] = push_data;
            keep_mem_d[wr_ptr_q] = push_keep;
            last_mem_d[wr_ptr_q] = push_last;
            user_mem_d[wr_ptr_q] = push_user;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head outputs are masked by head_valid instead.
    always_ff @(posedge clk) begin
        data_mem_q <= data_mem_d;
        keep_mem_q <= keep_mem_d;
        last_mem_q <= last_mem_d;
        user_mem_q <= user_mem_d;
    end

endmodule

// File: rtl/axis_ingress_fifo.sv
// Buffered AXI4-Stream ingress: FIFO decoupling, start-of-frame tagging, frame byte
// length measurement and sticky tkeep protocol error.
module axis_ingress_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = keep_width(DATA_WIDTH),
    parameter int DEPTH      = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    beat_accept,
    output logic                    frame_done,
    output logic [LEN_WIDTH-1:0]    frame_bytes,
    output logic                    proto_err,
    output logic [$clog2(DEPTH):0]  fill_level
);

    localparam int SUM_W = LEN_WIDTH + 8;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = {LEN_WIDTH{1'b1}};

    logic                  ready_en_q, ready_en_d;
    logic                  sof_q, sof_d;
    logic [LEN_WIDTH-1:0]  accum_q, accum_d;
    logic [LEN_WIDTH-1:0]  frame_bytes_q, frame_bytes_d;
    logic                  frame_done_q, frame_done_d;
    logic                  proto_err_q, proto_err_d;

    logic                  fifo_full;
    logic                  push, pop;
    logic [KEEP_MAX-1:0]   keep_ext;
    logic [7:0]            keep_cnt;
    logic [SUM_W-1:0]      len_sum;
    logic [LEN_WIDTH-1:0]  len_sat;
    keep_chk_e             keep_chk;

    // ready_en_q holds tready low through reset and the first cycle after release.
    assign s_axis_tready = ready_en_q & ~fifo_full;
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign beat_accept   = push;
    assign frame_done    = frame_done_q;
    assign frame_bytes   = frame_bytes_q;
    assign proto_err     = proto_err_q;

    assign keep_ext = KEEP_MAX'(s_axis_tkeep);
    assign keep_cnt = keep_popcount(keep_ext);
    assign keep_chk = keep_classify(keep_ext, s_axis_tlast, &s_axis_tkeep);
    assign len_sum  = SUM_W'(accum_q) + SUM_W'(keep_cnt);
    assign len_sat  = (len_sum > SUM_W'(LEN_MAX)) ? LEN_MAX : len_sum[LEN_WIDTH-1:0];

    always_comb begin
        ready_en_d    = 1'b1;
        sof_d         = sof_q;
        accum_d       = accum_q;
        frame_bytes_d = frame_bytes_q;
        frame_done_d  = 1'b0;
        proto_err_d   = proto_err_q;
        if (push) begin
            sof_d = s_axis_tlast;
            if (s_axis_tlast) begin
                frame_bytes_d = len_sat;
                frame_done_d  = 1'b1;
                accum_d       = '0;
            end else begin
                accum_d = len_sat;
            end
            if (keep_chk != KEEP_OK) begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q    <= 1'b0;
            sof_q         <= 1'b1;
            accum_q       <= '0;
            frame_bytes_q <= '0;
            frame_done_q  <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            ready_en_q    <= ready_en_d;
            sof_q         <= sof_d;
            accum_q       <= accum_d;
            frame_bytes_q <= frame_bytes_d;
            frame_done_q  <= frame_done_d;
            proto_err_q   <= proto_err_d;
        end
    end

    axis_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (s_axis_tdata),
        .push_keep  (s_axis_tkeep),
        .push_last  (s_axis_tlast),
        .push_user  (sof_q),
        .pop        (pop),
        .head_data  (m_axis_tdata),
        .head_keep  (m_axis_tkeep),
        .head_last  (m_axis_tlast),
        .head_user  (m_axis_tuser),
        .head_valid (m_axis_tvalid),
        .full       (fifo_full),
        .count      (fill_level)
    );

`ifndef SYNTHESIS
    a_ready_when_space: assert property (@(posedge clk) disable iff (rst)
        (ready_en_q && !fifo_full) |-> s_axis_tready);

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (m_axis_tvalid && !m_axis_tready) |=>
        (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tkeep) &&
         $stable(m_axis_tlast) && $stable(m_axis_tuser)));
`endif

endmodule

// File: tb/tb_axis_ingress_fifo.sv
// Directed bench for axis_ingress_fifo with a scoreboard queue and reference model
// for SOF, frame length (16-bit and 8-bit saturating) and protocol error.
module tb_axis_ingress_fifo;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    logic        clk, rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tlast, m_tready;
    logic        s_tready, m_tvalid, m_tlast, m_tuser, beat_accept, frame_done, proto_err;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [15:0] frame_bytes;
    logic [2:0]  fill_level;

    logic        d8_s_tready, d8_m_tvalid, d8_m_tlast, d8_m_tuser, d8_beat_accept;
    logic        d8_frame_done, d8_proto_err;
    logic [63:0] d8_m_tdata;
    logic [7:0]  d8_m_tkeep;
    logic [7:0]  d8_frame_bytes;
    logic [2:0]  d8_fill_level;

    int checks = 0;
    int failures = 0;

    beat_t q[$];
    bit    rdy_ok = 0;
    bit    sof_m = 1;
    bit    err_m = 0;
    int    acc16 = 0, acc8 = 0, fb16_m = 0, fb8_m = 0;

    axis_ingress_fifo #(.DATA_WIDTH(64), .DEPTH(4), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .beat_accept(beat_accept), .frame_done(frame_done), .frame_bytes(frame_bytes),
        .proto_err(proto_err), .fill_level(fill_level)
    );

    axis_ingress_fifo #(.DATA_WIDTH(64), .DEPTH(4), .LEN_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(d8_s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(d8_m_tdata), .m_axis_tkeep(d8_m_tkeep), .m_axis_tvalid(d8_m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(d8_m_tlast), .m_axis_tuser(d8_m_tuser),
        .beat_accept(d8_beat_accept), .frame_done(d8_frame_done),
        .frame_bytes(d8_frame_bytes), .proto_err(d8_proto_err), .fill_level(d8_fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit contiguous(input logic [7:0] k);
        bit seen_zero;
        bit ok;
        seen_zero = 0;
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            if (!k[i]) seen_zero = 1;
            else if (seen_zero) ok = 0;
        end
        return ok;
    endfunction

    // One clock: sample just before the edge, then check registered results just after it.
    task automatic tick(output bit acc);
        bit    rdy_exp, fd_exp;
        int    pc, n16, n8;
        beat_t e;
        #1;
        rdy_exp = rdy_ok && (q.size() != 4);
        chk("s_tready", s_tready, rdy_exp);
        chk("fill_level", fill_level, 64'(q.size()));
        chk("m_tvalid", m_tvalid, q.size() != 0);
        acc = s_tvalid && rdy_exp;
        chk("beat_accept", beat_accept, acc);
        if (q.size() != 0 && m_tready) begin
            e = q.pop_front();
            chk("m_tdata", m_tdata, e.d);
            chk("m_tkeep", m_tkeep, e.k);
            chk("m_tlast", m_tlast, e.l);
            chk("m_tuser", m_tuser, e.u);
        end
        fd_exp = 0;
        if (acc) begin
            q.push_back('{d: s_tdata, k: s_tkeep, l: s_tlast, u: sof_m});
            sof_m = s_tlast;
            if (s_tkeep == 8'h00 || !contiguous(s_tkeep) || (!s_tlast && s_tkeep != 8'hFF))
                err_m = 1;
            pc  = $countones(s_tkeep);
            n16 = (acc16 + pc > 65535) ? 65535 : acc16 + pc;
            n8  = (acc8 + pc > 255) ? 255 : acc8 + pc;
            if (s_tlast) begin
                fb16_m = n16;
                fb8_m  = n8;
                acc16  = 0;
                acc8   = 0;
                fd_exp = 1;
            end else begin
                acc16 = n16;
                acc8  = n8;
            end
        end
        @(posedge clk);
        #1;
        rdy_ok = 1;
        chk("frame_done", frame_done, fd_exp);
        chk("frame_bytes", frame_bytes, 64'(fb16_m));
        chk("d8_frame_bytes", d8_frame_bytes, 64'(fb8_m));
        chk("proto_err", proto_err, err_m);
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        bit a;
        int n;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        a = 0;
        n = 0;
        while (!a && n < 20) begin
            tick(a);
            n++;
        end
        checks++;
        assert (a) else begin
            failures++;
            $error("FAIL send_timeout observed=%0d cycles expected=accept", n);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit a;
        s_tvalid = 1'b0;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic reset_checks();
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tkeep", m_tkeep, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tuser", m_tuser, 0);
        chk("rst_beat_accept", beat_accept, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_bytes", frame_bytes, 0);
        chk("rst_d8_frame_bytes", d8_frame_bytes, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_fill_level", fill_level, 0);
    endtask

    task automatic model_reset();
        q.delete();
        rdy_ok = 0;
        sof_m  = 1;
        err_m  = 0;
        acc16  = 0;
        acc8   = 0;
        fb16_m = 0;
        fb8_m  = 0;
    endtask

    initial begin
        bit a;
        rst      = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        rst = 1'b0;

        // 1: three-beat frame, keep FF,FF,0F
        m_tready = 1'b1;
        send(64'h1111_0000_0000_0001, 8'hFF, 1'b0);
        send(64'h1111_0000_0000_0002, 8'hFF, 1'b0);
        send(64'h1111_0000_0000_0003, 8'h0F, 1'b1);
        idle(4);
        chk("t1_frame_bytes", frame_bytes, 20);
        chk("t1_proto_err", proto_err, 0);

        // 2: stalled output, six beats offered
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_tdata  = 64'hA0 + 64'((i < 4) ? i : 4);
            s_tkeep  = 8'hFF;
            s_tlast  = 1'b0;
            s_tvalid = 1'b1;
            tick(a);
        end
        chk("t2_s_tready", s_tready, 0);
        chk("t2_fill", fill_level, 4);
        m_tready = 1'b1;
        send(64'hA4, 8'hFF, 1'b0);
        send(64'hA5, 8'hFF, 1'b1);
        idle(6);
        chk("t2_frame_bytes", frame_bytes, 48);

        // 3: full FIFO, pop and offer in the same cycle
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) send(64'hC0 + 64'(i), 8'hFF, 1'b0);
        chk("t3_full", fill_level, 4);
        s_tdata  = 64'hC4;
        s_tkeep  = 8'h03;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        tick(a);
        chk("t3_no_push", fill_level, 3);
        m_tready = 1'b0;
        tick(a);
        chk("t3_push_next", fill_level, 4);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        idle(6);
        chk("t3_frame_bytes", frame_bytes, 34);

        // 4: short non-last beat raises sticky error
        send(64'hD0, 8'h7F, 1'b0);
        idle(1);
        chk("t4_err_set", proto_err, 1);
        send(64'hD1, 8'hFF, 1'b1);
        idle(4);
        chk("t4_err_held", proto_err, 1);
        chk("t4_frame_bytes", frame_bytes, 15);

        // 5: reset mid-frame
        m_tready = 1'b0;
        send(64'hE0, 8'hFF, 1'b0);
        send(64'hE1, 8'hFF, 1'b0);
        rst = 1'b1;
        #1;
        reset_checks();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_tready = 1'b1;
        send(64'hE2, 8'hFF, 1'b1);
        idle(4);
        chk("t5_frame_bytes", frame_bytes, 8);

        // 6: 40 full beats, 8-bit length saturates
        for (int i = 0; i < 40; i++) send(64'hF000 + 64'(i), 8'hFF, i == 39);
        idle(4);
        chk("t6_bytes16", frame_bytes, 320);
        chk("t6_bytes8_sat", d8_frame_bytes, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
